// File: rtl/timer_pkg.sv
// Shared definitions for the timer peripheral: data width, register offsets
// and the match-sequencer state encoding.
package timer_pkg;

  localparam int TIMER_DATA_W = 32;

  localparam logic [7:0] CTRL_OFF  = 8'h0;
  localparam logic [7:0] PRESC_OFF = 8'h4;
  localparam logic [7:0] COUNT_OFF = 8'h8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    HIT   = 2'd3
  } timer_seq_state_e;

endpackage

// File: rtl/timer_seq_ctrl.sv
// Match sequencer for the timer core: clear, count to match, raise sticky irq,
// optionally reload. Optional match_count output under TIMER_SEQ_MATCH_COUNT_EN.
module timer_seq_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned CLEAR_CYCLES = 2
) (
  input  logic                    axi_clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    periodic,
  input  logic [TIMER_DATA_W-1:0] match_value,
  input  logic [TIMER_DATA_W-1:0] prescaler_in,
  input  logic [TIMER_DATA_W-1:0] counter,
  input  logic                    irq_ack,
  output logic                    enable,
  output logic                    reset_counter,
  output logic [TIMER_DATA_W-1:0] prescaler,
  output logic                    busy,
  output logic                    irq,
  output logic                    overrun,
`ifdef TIMER_SEQ_MATCH_COUNT_EN
  output logic [15:0]             match_count,
`endif
  output logic                    start_err
);

  localparam logic [3:0] CLR_LOAD = 4'(CLEAR_CYCLES - 1);

  timer_seq_state_e        state_q, state_d;
  logic [3:0]              clr_cnt_q, clr_cnt_d;
  logic [TIMER_DATA_W-1:0] match_q, match_d;
  logic [TIMER_DATA_W-1:0] prescaler_q, prescaler_d;
  logic                    periodic_q, periodic_d;
  logic                    irq_q, irq_d;
  logic                    overrun_q, overrun_d;
  logic                    start_err_q, start_err_d;
  logic                    enable_q, reset_counter_q, busy_q;
  logic                    start_acc;
  logic                    hit;

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    match_d     = match_q;
    prescaler_d = prescaler_q;
    periodic_d  = periodic_q;
    start_err_d = 1'b0;
    start_acc   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (match_value != '0) begin
            start_acc   = 1'b1;
            match_d     = match_value;
            prescaler_d = prescaler_in;
            periodic_d  = periodic;
            clr_cnt_d   = CLR_LOAD;
            state_d     = CLEAR;
          end else begin
            start_err_d = 1'b1;
          end
        end
      end
      CLEAR: begin
        if (stop)                 state_d = IDLE;
        else if (clr_cnt_q == '0) state_d = RUN;
        else                      clr_cnt_d = clr_cnt_q - 4'd1;
      end
      RUN: begin
        // stop outranks a match seen on the same edge
        if (stop)                    state_d = IDLE;
        else if (counter >= match_q) state_d = HIT;
      end
      HIT: begin
        if (stop || !periodic_q) begin
          state_d = IDLE;
        end else begin
          clr_cnt_d = CLR_LOAD;
          state_d   = CLEAR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // HIT is only ever entered from RUN and lasts one cycle, so this marks the match edge.
  assign hit       = (state_d == HIT) && (state_q != HIT);
  assign irq_d     = hit | (irq_q & ~irq_ack);
  assign overrun_d = (hit & irq_q) | (overrun_q & ~irq_ack);

  always_ff @(posedge axi_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      clr_cnt_q       <= '0;
      match_q         <= '0;
      prescaler_q     <= '0;
      periodic_q      <= 1'b0;
      irq_q           <= 1'b0;
      overrun_q       <= 1'b0;
      start_err_q     <= 1'b0;
      enable_q        <= 1'b0;
      reset_counter_q <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      clr_cnt_q       <= clr_cnt_d;
      match_q         <= match_d;
      prescaler_q     <= prescaler_d;
      periodic_q      <= periodic_d;
      irq_q           <= irq_d;
      overrun_q       <= overrun_d;
      start_err_q     <= start_err_d;
      enable_q        <= (state_d == RUN);
      reset_counter_q <= (state_d == CLEAR);
      busy_q          <= (state_d != IDLE);
    end
  end

`ifdef TIMER_SEQ_MATCH_COUNT_EN
  logic [15:0] match_count_q;

  always_ff @(posedge axi_clk or negedge rst_n) begin
    if (!rst_n)                              match_count_q <= '0;
    else if (start_acc)                      match_count_q <= '0;
    else if (hit && match_count_q != 16'hFFFF) match_count_q <= match_count_q + 16'd1;
  end

  assign match_count = match_count_q;
`endif

  assign enable        = enable_q;
  assign reset_counter = reset_counter_q;
  assign prescaler     = prescaler_q;
  assign busy          = busy_q;
  assign irq           = irq_q;
  assign overrun       = overrun_q;
  assign start_err     = start_err_q;

endmodule

// File: tb/tb_timer_seq_ctrl.sv
// Bench for timer_seq_ctrl with a behavioural timer core; expected outputs come
// from arithmetic on run phase offsets (clear length, ticks to match, reload period).
module tb_timer_seq_ctrl;

  localparam int CLR = 3;

  logic        axi_clk;
  logic        rst_n;
  logic        start, stop, periodic, irq_ack;
  logic [31:0] match_value, prescaler_in, counter;
  logic        enable, reset_counter, busy, irq, overrun, start_err;
  logic [31:0] prescaler;
`ifdef TIMER_SEQ_MATCH_COUNT_EN
  logic [15:0] match_count;
`endif

  int checks   = 0;
  int failures = 0;

  bit   irq_m, ovr_m;
  int   mc_m;
  logic [31:0] last_p;
  logic [31:0] pcnt;

  timer_seq_ctrl #(.CLEAR_CYCLES(CLR)) dut (
    .axi_clk       (axi_clk),
    .rst_n         (rst_n),
    .start         (start),
    .stop          (stop),
    .periodic      (periodic),
    .match_value   (match_value),
    .prescaler_in  (prescaler_in),
    .counter       (counter),
    .irq_ack       (irq_ack),
    .enable        (enable),
    .reset_counter (reset_counter),
    .prescaler     (prescaler),
    .busy          (busy),
    .irq           (irq),
    .overrun       (overrun),
`ifdef TIMER_SEQ_MATCH_COUNT_EN
    .match_count   (match_count),
`endif
    .start_err     (start_err)
  );

  // clock / reset
  initial axi_clk = 1'b0;
  always #5 axi_clk = ~axi_clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // behavioural timer core: clear on reset_counter, tick every prescaler+1 enabled cycles
  always @(posedge axi_clk or negedge rst_n) begin
    if (!rst_n) begin
      counter <= '0;
      pcnt    <= '0;
    end else if (reset_counter) begin
      counter <= '0;
      pcnt    <= '0;
    end else if (enable) begin
      if (pcnt >= prescaler) begin
        pcnt    <= '0;
        counter <= counter + 32'd1;
      end else begin
        pcnt <= pcnt + 32'd1;
      end
    end
  end

  task automatic tick();
    @(posedge axi_clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input bit b, input bit rc, input bit en);
    chk1({tag, " busy"}, busy, b);
    chk1({tag, " reset_counter"}, reset_counter, rc);
    chk1({tag, " enable"}, enable, en);
    chk1({tag, " irq"}, irq, irq_m);
    chk1({tag, " overrun"}, overrun, ovr_m);
    chk1({tag, " start_err"}, start_err, 1'b0);
    chk32({tag, " prescaler"}, prescaler, last_p);
`ifdef TIMER_SEQ_MATCH_COUNT_EN
    chk32({tag, " match_count"}, {16'b0, match_count}, 32'(mc_m));
`endif
  endtask

  // driver + model: start at offset 0, then optional ack/stop/busy-start at given offsets
  task automatic follow(input int m, input int p, input bit per, input int n,
                        input int ack_k, input int stop_k, input int start_k);
    int  len, prd, j, ph;
    bit  stopped, hit;
    len     = CLR + m * (p + 1) + 1;
    prd     = len + 1;
    stopped = 1'b0;
    for (int k = 0; k < n; k++) begin
      start        = (k == 0) || (k == start_k);
      match_value  = (k == 0) ? 32'(m) : 32'd9;
      prescaler_in = (k == 0) ? 32'(p) : 32'd77;
      periodic     = (k == 0) ? per : 1'b1;
      irq_ack      = (k == ack_k);
      stop         = (k == stop_k);
      tick();
      if (k == stop_k) stopped = 1'b1;
      if (stopped || (!per && k > len)) begin
        ph = 0;
      end else begin
        j  = per ? (k % prd) : k;
        ph = (j < CLR) ? 1 : (j < len) ? 2 : 3;
      end
      hit   = (ph == 3);
      ovr_m = (hit && irq_m) || (ovr_m && !(k == ack_k));
      irq_m = hit || (irq_m && !(k == ack_k));
      if (k == 0) begin
        mc_m   = 0;
        last_p = 32'(p);
      end
      if (hit && mc_m < 65535) mc_m++;
      chk_outs($sformatf("m=%0d p=%0d per=%0d k=%0d", m, p, per, k), ph != 0, ph == 1, ph == 2);
    end
    start   = 1'b0;
    stop    = 1'b0;
    irq_ack = 1'b0;
    match_value  = '0;
    prescaler_in = '0;
    periodic     = 1'b0;
  endtask

  task automatic do_ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    irq_m   = 1'b0;
    ovr_m   = 1'b0;
    chk1("ack irq", irq, 1'b0);
    chk1("ack overrun", overrun, 1'b0);
  endtask

  initial begin
    int m, p, per, len, n, ak, sk;
    rst_n = 1'b0;
    start = 1'b0; stop = 1'b0; periodic = 1'b0; irq_ack = 1'b0;
    match_value = '0; prescaler_in = '0;
    irq_m = 1'b0; ovr_m = 1'b0; mc_m = 0; last_p = '0;

    // reset state
    tick(); tick();
    chk_outs("reset", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    chk_outs("post-reset idle", 1'b0, 1'b0, 1'b0);

    // one-shot, match 5, irq holds until ack
    follow(5, 0, 1'b0, CLR + 10, -1, -1, -1);
    chk1("one-shot irq sticky", irq, 1'b1);
    do_ack();

    // periodic, match 3: overrun after the second HIT, ack mid-stream, stop at the end
    follow(3, 0, 1'b1, 45, 30, 42, -1);
    do_ack();

    // zero match rejected
    match_value = '0; prescaler_in = 32'd55; start = 1'b1;
    tick();
    start = 1'b0; prescaler_in = '0;
    chk1("zero start_err", start_err, 1'b1);
    chk1("zero busy", busy, 1'b0);
    chk1("zero enable", enable, 1'b0);
    chk1("zero reset_counter", reset_counter, 1'b0);
    chk32("zero prescaler held", prescaler, last_p);
    tick();
    chk1("zero start_err one cycle", start_err, 1'b0);

    // stop on the match edge: no irq
    follow(4, 0, 1'b0, CLR + 9, -1, CLR + 5, -1);
    chk1("stop-at-match irq", irq, 1'b0);

    // busy start ignored, ack racing the HIT edge loses
    follow(2, 0, 1'b0, CLR + 7, CLR + 3, -1, CLR + 1);
    chk1("race irq kept", irq, 1'b1);

    // asynchronous reset mid-run
    follow(20, 0, 1'b0, CLR + 4, -1, -1, -1);
    #2 rst_n = 1'b0;
    #1;
    irq_m = 1'b0; ovr_m = 1'b0; mc_m = 0; last_p = '0;
    chk_outs("async reset", 1'b0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    chk_outs("after async reset", 1'b0, 1'b0, 1'b0);

    // randomized runs
    for (int r = 0; r < 8; r++) begin
      m   = int'($urandom_range(1, 6));
      p   = int'($urandom_range(0, 2));
      per = int'($urandom_range(0, 1));
      len = CLR + m * (p + 1) + 1;
      if (per != 0) begin
        sk = int'($urandom_range(2, 2 * (len + 1) + 3));
        n  = sk + 3;
      end else begin
        sk = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, len + 1)) : -1;
        n  = len + 3;
      end
      ak = int'($urandom_range(1, n - 1));
      follow(m, p, per[0], n, ak, sk, -1);
    end

    // three periodic HITs then stop in the HIT cycle
    follow(1, 0, 1'b1, (CLR + 2) + 2 * (CLR + 3) + 3, -1, (CLR + 2) + 2 * (CLR + 3) + 1, -1);
`ifdef TIMER_SEQ_MATCH_COUNT_EN
    chk32("match_count three hits", {16'b0, match_count}, 32'd3);
`endif
    chk1("three hits overrun", overrun, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
